// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the multiply/divide unit.
// Defining MDU_MADD_EN lets MADD/MADDU/MSUB/MSUBU issue as multi-cycle operations.
package mul_div_unit_pkg;

   localparam logic [3:0] MDUOP_NONE  = 4'd0;
   localparam logic [3:0] MDUOP_MULT  = 4'd1;
   localparam logic [3:0] MDUOP_MULTU = 4'd2;
   localparam logic [3:0] MDUOP_DIV   = 4'd3;
   localparam logic [3:0] MDUOP_DIVU  = 4'd4;
   localparam logic [3:0] MDUOP_MTHI  = 4'd5;
   localparam logic [3:0] MDUOP_MTLO  = 4'd6;
   localparam logic [3:0] MDUOP_MFHI  = 4'd7;
   localparam logic [3:0] MDUOP_MFLO  = 4'd8;
   localparam logic [3:0] MDUOP_MADD  = 4'd9;
   localparam logic [3:0] MDUOP_MADDU = 4'd10;
   localparam logic [3:0] MDUOP_MSUB  = 4'd11;
   localparam logic [3:0] MDUOP_MSUBU = 4'd12;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   // Accumulating ops only count as multiplies when the feature is built in;
   // otherwise they fall through as unknown codes.
   function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
      return (op == MDUOP_MULT)  || (op == MDUOP_MULTU) ||
             (op == MDUOP_MADD)  || (op == MDUOP_MADDU) ||
             (op == MDUOP_MSUB)  || (op == MDUOP_MSUBU);
`else
      return (op == MDUOP_MULT) || (op == MDUOP_MULTU);
`endif
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDUOP_DIV) || (op == MDUOP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational arithmetic for the multiply/divide unit: signed/unsigned products,
// truncating division with dividend-signed remainder, accumulate forms and divide-by-zero flag.
module mdu_compute
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   operand1,
   input  logic [WIDTH-1:0]   operand2,
   input  logic [WIDTH-1:0]   acc_hi,
   input  logic [WIDTH-1:0]   acc_lo,
   output logic [2*WIDTH-1:0] res,
   output logic               div_zero
);

   logic [2*WIDTH-1:0] a_sext, b_sext, a_zext, b_zext;
   logic [2*WIDTH-1:0] sprod, uprod, acc;
   logic [WIDTH-1:0]   b_safe, mag_a, mag_b, mag_q, mag_r;
   logic [WIDTH-1:0]   sq, sr, uq, ur;
   logic               neg_a, neg_b;

   assign neg_a  = operand1[WIDTH-1];
   assign neg_b  = operand2[WIDTH-1];
   assign a_sext = {{WIDTH{neg_a}}, operand1};
   assign b_sext = {{WIDTH{neg_b}}, operand2};
   assign a_zext = {{WIDTH{1'b0}}, operand1};
   assign b_zext = {{WIDTH{1'b0}}, operand2};

   // The low 2*WIDTH bits of a sign-extended product equal the signed product.
   assign sprod = a_sext * b_sext;
   assign uprod = a_zext * b_zext;
   assign acc   = {acc_hi, acc_lo};

   // A zero divisor is swapped for one so the dividers never see zero; the result is discarded.
   assign div_zero = (operand2 == '0);
   assign b_safe   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : operand2;

   // Magnitude division; MIN's magnitude is MIN as unsigned, so MIN/-1 wraps back to MIN.
   assign mag_a = neg_a ? -operand1 : operand1;
   assign mag_b = (neg_b && !div_zero) ? -operand2 : b_safe;
   assign mag_q = mag_a / mag_b;
   assign mag_r = mag_a % mag_b;
   assign sq    = (neg_a ^ neg_b) ? -mag_q : mag_q;
   assign sr    = neg_a ? -mag_r : mag_r;
   assign uq    = operand1 / b_safe;
   assign ur    = operand1 % b_safe;

   always_comb begin
      res = '0;
      case (op)
         MDUOP_MULT:  res = sprod;
         MDUOP_MULTU: res = uprod;
         MDUOP_DIV:   res = {sr, sq};
         MDUOP_DIVU:  res = {ur, uq};
         MDUOP_MADD:  res = acc + sprod;
         MDUOP_MADDU: res = acc + uprod;
         MDUOP_MSUB:  res = acc - sprod;
         MDUOP_MSUBU: res = acc - uprod;
         default:     res = '0;
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and fixed-latency busy counter.
// Optional MDU_MADD_EN (see package) enables the accumulating multiply ops.
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MUL_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] operand1,
   input  logic [WIDTH-1:0] operand2,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] result
);

   localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   mdu_state_e         state_reg, state_next;
   logic [CW-1:0]      cnt_reg;
   logic [WIDTH-1:0]   ph_reg, pl_reg;
   logic [WIDTH-1:0]   hi_reg, lo_reg;
   logic               commit_reg;
   logic [2*WIDTH-1:0] comp_res;
   logic               div_zero;
   logic               issue, done, idle;

   mdu_compute #(.WIDTH(WIDTH)) u_compute (
      .op       (op),
      .operand1 (operand1),
      .operand2 (operand2),
      .acc_hi   (hi_reg),
      .acc_lo   (lo_reg),
      .res      (comp_res),
      .div_zero (div_zero)
   );

   assign idle  = (state_reg == ST_IDLE);
   assign issue = idle && start && (is_mul_op(op) || is_div_op(op));
   assign done  = (state_reg == ST_BUSY) && (cnt_reg == CW'(1));

   always_ff @(posedge clk) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (issue) state_next = ST_BUSY;
         ST_BUSY: if (done)  state_next = ST_IDLE;
         default:            state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == ST_BUSY);
   end

   // Pending result is captured at issue so HI/LO stay architecturally stable while busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg    <= '0;
         ph_reg     <= '0;
         pl_reg     <= '0;
         commit_reg <= 1'b0;
         hi_reg     <= '0;
         lo_reg     <= '0;
      end else begin
         if (issue) begin
            {ph_reg, pl_reg} <= comp_res;
            commit_reg       <= !(is_div_op(op) && div_zero);
            cnt_reg          <= is_mul_op(op) ? CW'(MUL_LAT) : CW'(DIV_LAT);
         end else if (state_reg == ST_BUSY) begin
            cnt_reg <= cnt_reg - CW'(1);
         end

         if (done) begin
            if (commit_reg) begin
               hi_reg <= ph_reg;
               lo_reg <= pl_reg;
            end
         end else if (idle && start) begin
            if (op == MDUOP_MTHI) hi_reg <= operand1;
            if (op == MDUOP_MTLO) lo_reg <= operand1;
         end
      end
   end

   assign hi = hi_reg;
   assign lo = lo_reg;

   always_comb begin
      result = '0;
      if (op == MDUOP_MFHI)      result = hi_reg;
      else if (op == MDUOP_MFLO) result = lo_reg;
   end

endmodule
